// File: rtl/dda_raycast_stepper.sv
// DDA ray-marching engine: steps one ray through a BRAM tile map and returns
// hit tile, wall side, perpendicular distance and clamped column height.
module dda_raycast_stepper #(
  parameter int MAP_W         = 24,
  parameter int MAP_H         = 24,
  parameter int FRAC          = 8,
  parameter int INT           = 8,
  parameter int SCREEN_HEIGHT = 180,
  parameter int MAX_STEPS     = 64,
  parameter int HW            = 9,
  localparam int W            = INT + FRAC,
  localparam int AW           = $clog2(MAP_W * MAP_H)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_n_in,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic [HW-1:0] hcount_in,
  input  logic          stepX_in,
  input  logic          stepY_in,
  input  logic [W-1:0]  posX_in,
  input  logic [W-1:0]  posY_in,
  input  logic [W-1:0]  deltaDistX_in,
  input  logic [W-1:0]  deltaDistY_in,
  input  logic [W-1:0]  sideDistX_in,
  input  logic [W-1:0]  sideDistY_in,
  output logic [AW-1:0] map_addra_out,
  output logic          map_request_out,
  input  logic [3:0]    map_data_in,
  input  logic          map_data_valid_in,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [HW-1:0] hcount_ray_out,
  output logic [7:0]    lineHeight_out,
  output logic          wallType_out,
  output logic [3:0]    mapData_out,
  output logic [W-1:0]  perpWallDist_out,
  output logic          hit_out
);
  localparam int MW   = INT + 1;
  localparam int NUMW = $clog2(SCREEN_HEIGHT + 1) + FRAC;
  localparam int CW   = $clog2(NUMW + 1);
  localparam int SW   = $clog2(MAX_STEPS + 1);
  localparam logic [MW-1:0]   M_ONE    = MW'(1);
  localparam logic [INT-1:0]  X_MAX    = INT'(MAP_W - 1);
  localparam logic [INT-1:0]  Y_MAX    = INT'(MAP_H - 1);
  localparam logic [SW-1:0]   STEP_LIM = SW'(MAX_STEPS);
  localparam logic [NUMW-1:0] DIVIDEND = NUMW'(SCREEN_HEIGHT) << FRAC;
  localparam logic [NUMW-1:0] SH_Q     = NUMW'(SCREEN_HEIGHT);
  localparam logic [7:0]      SH_LH    = 8'(SCREEN_HEIGHT);
  localparam logic [CW-1:0]   DIV_LAST = CW'(NUMW);

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_CHECK, S_FETCH, S_DIV, S_MISS, S_OUT} state_t;
  state_t state;

  logic [HW-1:0]   hcount_r;
  logic            step_x_r, step_y_r, side_r;
  logic [W-1:0]    delta_x_r, delta_y_r, side_x_r, side_y_r, perp_r;
  logic [MW-1:0]   map_x_r, map_y_r;
  logic [SW-1:0]   steps_r;
  logic [3:0]      tile_r;
  logic [NUMW-1:0] div_num_r, div_q_r;
  logic [W-1:0]    div_rem_r;
  logic [CW-1:0]   div_cnt_r;

  logic [W:0] rem_sh, div_diff;
  logic       div_ge, out_of_map;
  logic [7:0] line_clamped;
  logic       unused_pos_frac;

  assign unused_pos_frac = ^{posX_in[FRAC-1:0], posY_in[FRAC-1:0]};

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? '1 : s[W-1:0];
  endfunction

  // Remainder stays below perp, so a negative trial difference always sets bit W.
  always_comb begin
    rem_sh     = {div_rem_r, div_num_r[NUMW-1]};
    div_diff   = rem_sh - {1'b0, perp_r};
    div_ge     = ~div_diff[W];
    out_of_map = map_x_r[INT] || map_y_r[INT] ||
                 (map_x_r[INT-1:0] > X_MAX) || (map_y_r[INT-1:0] > Y_MAX);
    if (perp_r == '0 || div_q_r > SH_Q) line_clamped = SH_LH;
    else                                line_clamped = div_q_r[7:0];
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
      ready_out <= 1'b1;
      valid_out <= 1'b0;
      map_request_out <= 1'b0;
      map_addra_out <= '0;
      hcount_ray_out <= '0;
      lineHeight_out <= '0;
      wallType_out <= 1'b0;
      mapData_out <= '0;
      perpWallDist_out <= '0;
      hit_out <= 1'b0;
      hcount_r <= '0;
      step_x_r <= 1'b0;
      step_y_r <= 1'b0;
      side_r <= 1'b0;
      delta_x_r <= '0;
      delta_y_r <= '0;
      side_x_r <= '0;
      side_y_r <= '0;
      perp_r <= '0;
      map_x_r <= '0;
      map_y_r <= '0;
      steps_r <= '0;
      tile_r <= '0;
      div_num_r <= '0;
      div_q_r <= '0;
      div_rem_r <= '0;
      div_cnt_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            hcount_r <= hcount_in;
            step_x_r <= stepX_in;
            step_y_r <= stepY_in;
            delta_x_r <= deltaDistX_in;
            delta_y_r <= deltaDistY_in;
            side_x_r <= sideDistX_in;
            side_y_r <= sideDistY_in;
            map_x_r <= {1'b0, posX_in[W-1:FRAC]};
            map_y_r <= {1'b0, posY_in[W-1:FRAC]};
            steps_r <= '0;
            ready_out <= 1'b0;
            state <= S_STEP;
          end
        end
        S_STEP: begin
          if (side_x_r < side_y_r) begin
            side_x_r <= sat_add(side_x_r, delta_x_r);
            map_x_r <= step_x_r ? map_x_r + M_ONE : map_x_r - M_ONE;
            side_r <= 1'b0;
          end else begin
            side_y_r <= sat_add(side_y_r, delta_y_r);
            map_y_r <= step_y_r ? map_y_r + M_ONE : map_y_r - M_ONE;
            side_r <= 1'b1;
          end
          steps_r <= steps_r + SW'(1);
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (out_of_map || steps_r == STEP_LIM) begin
            state <= S_MISS;
          end else begin
            map_addra_out <= AW'(map_x_r[INT-1:0]) + AW'(map_y_r[INT-1:0]) * AW'(MAP_W);
            map_request_out <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (map_data_valid_in) begin
            map_request_out <= 1'b0;
            if (map_data_in != 4'h0) begin
              tile_r <= map_data_in;
              perp_r <= side_r ? side_y_r - delta_y_r : side_x_r - delta_x_r;
              div_num_r <= DIVIDEND;
              div_rem_r <= '0;
              div_q_r <= '0;
              div_cnt_r <= '0;
              state <= S_DIV;
            end else begin
              state <= S_STEP;
            end
          end
        end
        S_DIV: begin
          if (div_cnt_r == DIV_LAST) begin
            lineHeight_out <= line_clamped;
            mapData_out <= tile_r;
            perpWallDist_out <= perp_r;
            wallType_out <= side_r;
            hit_out <= 1'b1;
            hcount_ray_out <= hcount_r;
            valid_out <= 1'b1;
            state <= S_OUT;
          end else begin
            div_num_r <= div_num_r << 1;
            div_rem_r <= div_ge ? div_diff[W-1:0] : rem_sh[W-1:0];
            div_q_r <= {div_q_r[NUMW-2:0], div_ge};
            div_cnt_r <= div_cnt_r + CW'(1);
          end
        end
        S_MISS: begin
          lineHeight_out <= '0;
          mapData_out <= '0;
          perpWallDist_out <= '1;
          wallType_out <= side_r;
          hit_out <= 1'b0;
          hcount_ray_out <= hcount_r;
          valid_out <= 1'b1;
          state <= S_OUT;
        end
        S_OUT: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            ready_out <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dda_raycast_stepper.sv
// Directed bench for dda_raycast_stepper: default instance plus a MAX_STEPS=4
// instance, a latency-programmable BRAM model and hand-computed results.
module tb_dda_raycast_stepper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_in = 1'b0, valid_in2 = 1'b0, ready_in = 1'b0, ready_in2 = 1'b0;
  logic [8:0]  hcount = '0;
  logic        step_x = 1'b0, step_y = 1'b0;
  logic [15:0] pos_x = '0, pos_y = '0, ddx = '0, ddy = '0, sdx = '0, sdy = '0;

  logic        ready, req, mdv_bus, vo, wt, hit;
  logic [9:0]  addr;
  logic [3:0]  md_bus, md;
  logic [8:0]  hc;
  logic [7:0]  lh;
  logic [15:0] perp;

  logic        ready2, req2, vo2, wt2, hit2;
  logic        mdv2 = 1'b0;
  logic [9:0]  addr2;
  logic [3:0]  md2;
  logic [8:0]  hc2;
  logic [7:0]  lh2;
  logic [15:0] perp2;

  dda_raycast_stepper dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ready),
    .hcount_in(hcount), .stepX_in(step_x), .stepY_in(step_y),
    .posX_in(pos_x), .posY_in(pos_y), .deltaDistX_in(ddx), .deltaDistY_in(ddy),
    .sideDistX_in(sdx), .sideDistY_in(sdy), .map_addra_out(addr), .map_request_out(req),
    .map_data_in(md_bus), .map_data_valid_in(mdv_bus), .valid_out(vo), .ready_in(ready_in),
    .hcount_ray_out(hc), .lineHeight_out(lh), .wallType_out(wt), .mapData_out(md),
    .perpWallDist_out(perp), .hit_out(hit)
  );

  dda_raycast_stepper #(.MAX_STEPS(4)) dut2 (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in2), .ready_out(ready2),
    .hcount_in(hcount), .stepX_in(step_x), .stepY_in(step_y),
    .posX_in(pos_x), .posY_in(pos_y), .deltaDistX_in(ddx), .deltaDistY_in(ddy),
    .sideDistX_in(sdx), .sideDistY_in(sdy), .map_addra_out(addr2), .map_request_out(req2),
    .map_data_in(4'h0), .map_data_valid_in(mdv2), .valid_out(vo2), .ready_in(ready_in2),
    .hcount_ray_out(hc2), .lineHeight_out(lh2), .wallType_out(wt2), .mapData_out(md2),
    .perpWallDist_out(perp2), .hit_out(hit2)
  );

  // BRAM model: strobe arrives 'lat' cycles after the request is seen high
  logic [3:0] mem [0:575];
  int   lat = 1;
  int   bcnt = 0;
  logic bram_en = 1'b1;
  logic mdv_m = 1'b0, mdv_man = 1'b0;
  logic [3:0] md_m = '0;
  assign mdv_bus = mdv_m | mdv_man;
  assign md_bus  = mdv_man ? 4'h7 : md_m;

  always @(posedge clk) begin
    if (bram_en && req && !mdv_m) begin
      if (bcnt + 1 >= lat) begin
        mdv_m <= 1'b1;
        md_m <= mem[addr];
        bcnt <= 0;
      end else begin
        bcnt <= bcnt + 1;
      end
    end else begin
      mdv_m <= 1'b0;
      bcnt <= 0;
    end
  end

  always @(posedge clk) mdv2 <= req2 && !mdv2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] alog [0:15];
  logic [9:0] alog2 [0:15];
  int   rcnt = 0, rcnt2 = 0;
  logic req_q = 1'b0, req2_q = 1'b0;
  always @(posedge clk) begin
    req_q <= req;
    req2_q <= req2;
    if (req && !req_q) begin
      alog[rcnt % 16] <= addr;
      rcnt <= rcnt + 1;
    end
    if (req2 && !req2_q) begin
      alog2[rcnt2 % 16] <= addr2;
      rcnt2 <= rcnt2 + 1;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 576; i++) mem[i] = 4'h0;
  endtask

  task automatic launch(input bit sel, input logic [8:0] h, input logic [15:0] px, input logic [15:0] py,
                        input logic stx, input logic sty, input logic [15:0] dx, input logic [15:0] dy,
                        input logic [15:0] sx0, input logic [15:0] sy0, output int t0);
    @(negedge clk);
    hcount = h; pos_x = px; pos_y = py; step_x = stx; step_y = sty;
    ddx = dx; ddy = dy; sdx = sx0; sdy = sy0;
    if (sel) valid_in2 = 1'b1;
    else     valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    valid_in2 = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_res(input bit sel, input int t0, output int lat_c);
    int k;
    k = 0;
    while (!(sel ? vo2 : vo) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    lat_c = cyc - t0;
    check("result_valid", {31'b0, (sel ? vo2 : vo)}, 32'd1);
  endtask

  task automatic ack(input bit sel);
    if (sel) ready_in2 = 1'b1;
    else     ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    ready_in2 = 1'b0;
    check("valid_after_ack", {31'b0, (sel ? vo2 : vo)}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [7:0] e_lh, input logic e_wt,
                              input logic [3:0] e_md, input logic [15:0] e_perp,
                              input logic e_hit, input logic [8:0] e_hc);
    check({tag, "_lineHeight"}, lh, e_lh);
    check({tag, "_wallType"}, wt, e_wt);
    check({tag, "_mapData"}, md, e_md);
    check({tag, "_perp"}, perp, e_perp);
    check({tag, "_hit"}, hit, e_hit);
    check({tag, "_hcount"}, hc, e_hc);
  endtask

  initial begin
    int t0, lc, base, k;
    clear_map();
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_valid", vo, 1'b0);
    check("rst_req", req, 1'b0);
    check("rst_addr", addr, 10'd0);
    check("rst_perp", perp, 16'd0);
    check("rst_lh", lh, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Hit at (3,2) on first X step, clamped height, BRAM latency 1
    mem[51] = 4'h5;
    base = rcnt;
    launch(1'b0, 9'h055, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0080, 16'h0100, t0);
    wait_res(1'b0, t0, lc);
    check("t1_latency", lc, 21);
    check("t1_nreq", rcnt - base, 1);
    check("t1_addr", alog[base % 16], 10'd51);
    check_result("t1", 8'd180, 1'b0, 4'h5, 16'h0080, 1'b1, 9'h055);
    // Backpressure: outputs held, valid_in ignored
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      hcount = 9'h1AA;
      check("hold_valid", vo, 1'b1);
      check("hold_ready", ready, 1'b0);
      check("hold_lh", lh, 8'd180);
      check("hold_perp", perp, 16'h0080);
      check("hold_hcount", hc, 9'h055);
    end
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    valid_in = 1'b0;
    check("release_valid", vo, 1'b0);
    check("release_ready", ready, 1'b1);
    @(negedge clk);
    check("no_accept_on_release", ready, 1'b1);

    // Same ray, BRAM latency 5: identical result, 4 extra cycles
    lat = 5;
    launch(1'b0, 9'h055, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0080, 16'h0100, t0);
    wait_res(1'b0, t0, lc);
    check("t1l5_latency", lc, 25);
    check_result("t1l5", 8'd180, 1'b0, 4'h5, 16'h0080, 1'b1, 9'h055);
    ack(1'b0);
    lat = 1;

    // Empty (3,2), hit at (3,3) via a Y step
    mem[51] = 4'h0;
    mem[75] = 4'h2;
    base = rcnt;
    launch(1'b0, 9'h010, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0080, 16'h0100, t0);
    wait_res(1'b0, t0, lc);
    check("t2_latency", lc, 25);
    check("t2_nreq", rcnt - base, 2);
    check("t2_addr0", alog[base % 16], 10'd51);
    check("t2_addr1", alog[(base + 1) % 16], 10'd75);
    check_result("t2", 8'd180, 1'b1, 4'h2, 16'h0100, 1'b1, 9'h010);
    ack(1'b0);

    // perp 0x0200 -> 90
    clear_map();
    mem[51] = 4'h3;
    launch(1'b0, 9'h020, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0200, 16'h0300, t0);
    wait_res(1'b0, t0, lc);
    check_result("t3", 8'd90, 1'b0, 4'h3, 16'h0200, 1'b1, 9'h020);
    ack(1'b0);

    // perp 0x0123 -> floor(46080/291) = 158
    mem[51] = 4'h1;
    launch(1'b0, 9'h021, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0123, 16'h0200, t0);
    wait_res(1'b0, t0, lc);
    check_result("t4", 8'd158, 1'b0, 4'h1, 16'h0123, 1'b1, 9'h021);
    ack(1'b0);

    // Tie steps Y, stepY negative -> (2,1), perp 0x0180 -> 120
    clear_map();
    mem[26] = 4'h4;
    base = rcnt;
    launch(1'b0, 9'h030, 16'h0280, 16'h0280, 1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0180, 16'h0180, t0);
    wait_res(1'b0, t0, lc);
    check("t5_addr", alog[base % 16], 10'd26);
    check_result("t5", 8'd120, 1'b1, 4'h4, 16'h0180, 1'b1, 9'h030);
    ack(1'b0);

    // Empty map from (22.5,1.5): one read at (23,1), then exit at mapX=24
    clear_map();
    base = rcnt;
    launch(1'b0, 9'h040, 16'h1680, 16'h0180, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0080, 16'h0800, t0);
    wait_res(1'b0, t0, lc);
    check("t6_latency", lc, 7);
    check("t6_nreq", rcnt - base, 1);
    check("t6_addr", alog[base % 16], 10'd47);
    check_result("t6", 8'd0, 1'b0, 4'h0, 16'hFFFF, 1'b0, 9'h040);
    ack(1'b0);

    // MAX_STEPS=4 instance: budget hits on the 4th step, three reads issued
    base = rcnt2;
    launch(1'b1, 9'h050, 16'h0580, 16'h0580, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0080, 16'h0100, t0);
    wait_res(1'b1, t0, lc);
    check("t7_latency", lc, 15);
    check("t7_nreq", rcnt2 - base, 3);
    check("t7_addr0", alog2[base % 16], 10'd126);
    check("t7_addr2", alog2[(base + 2) % 16], 10'd151);
    check("t7_hit", hit2, 1'b0);
    check("t7_lh", lh2, 8'd0);
    check("t7_perp", perp2, 16'hFFFF);
    check("t7_wallType", wt2, 1'b1);
    check("t7_mapData", md2, 4'h0);
    check("t7_hcount", hc2, 9'h050);
    ack(1'b1);

    // Reset during FETCH, late strobe after release must be ignored
    mem[51] = 4'h5;
    bram_en = 1'b0;
    launch(1'b0, 9'h060, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0080, 16'h0100, t0);
    k = 0;
    while (!req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t8_req_seen", req, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t8_rst_req", req, 1'b0);
    check("t8_rst_ready", ready, 1'b1);
    check("t8_rst_addr", addr, 10'd0);
    check("t8_rst_valid", vo, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mdv_man = 1'b1;
    @(negedge clk);
    mdv_man = 1'b0;
    repeat (3) @(negedge clk);
    check("t8_post_ready", ready, 1'b1);
    check("t8_post_valid", vo, 1'b0);
    check("t8_post_req", req, 1'b0);
    check("t8_post_lh", lh, 8'd0);
    bram_en = 1'b1;
    launch(1'b0, 9'h061, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0080, 16'h0100, t0);
    wait_res(1'b0, t0, lc);
    check("t8_next_latency", lc, 21);
    check_result("t8_next", 8'd180, 1'b0, 4'h5, 16'h0080, 1'b1, 9'h061);
    ack(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
